// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer for the 16-bit MIPS-style datapath.
// Walks FETCH/DECODE/EXEC/MEM/WB with a ready-handshake memory watchdog and sticky error flags.
module multicycle_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] instr_op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic       illegal,
  output logic       timeout,
  output logic [2:0] state
);

  localparam int unsigned CNT_W = 8;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd7;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_LW  = 4'd8;
  localparam logic [3:0] OP_SW  = 4'd10;
  localparam logic [3:0] OP_BNE = 4'd14;
  localparam logic [3:0] OP_JMP = 4'd15;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [2:0]       r_state;
  logic [3:0]       r_op_q;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_illegal;
  logic             r_timeout;

  logic [2:0]       w_next_state;
  logic             w_wait;
  logic             w_wd_expire;

  function automatic logic is_rtype(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return is_rtype(op) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BNE) || (op == OP_JMP);
  endfunction

  function automatic logic [2:0] rtype_alu_op(input logic [3:0] op);
    case (op)
      OP_AND:  return 3'b010;
      OP_OR:   return 3'b011;
      OP_SUB:  return 3'b001;
      OP_SLT:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // A wait cycle is any cycle the memory port is requested but not yet ready.
  assign w_wait      = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;
  assign w_wd_expire = w_wait && (r_wait_cnt == WD_LAST);

  // Next-state and strobe decode; reset masks every strobe in the same cycle.
  always_comb begin
    w_next_state = r_state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    iord         = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'b00;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu_op       = 3'b000;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    instr_done   = 1'b0;

    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write     = 1'b1;
          pc_write     = 1'b1;
          alu_src_b    = 2'b01;
          w_next_state = S_DECODE;
        end else if (w_wd_expire) begin
          w_next_state = S_ERR;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        if (instr_op == OP_JMP) begin
          pc_write     = 1'b1;
          pc_src       = 2'b10;
          instr_done   = 1'b1;
          w_next_state = S_FETCH;
        end else if (!is_legal(instr_op)) begin
          w_next_state = S_ERR;
        end else begin
          w_next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        if (is_rtype(r_op_q)) begin
          alu_op       = rtype_alu_op(r_op_q);
          w_next_state = S_WB;
        end else if ((r_op_q == OP_LW) || (r_op_q == OP_SW)) begin
          alu_src_b    = 2'b10;
          w_next_state = S_MEM;
        end else if (r_op_q == OP_BNE) begin
          alu_op       = 3'b001;
          pc_src       = 2'b01;
          pc_write     = ~zero;
          instr_done   = 1'b1;
          w_next_state = S_FETCH;
        end else begin
          w_next_state = S_ERR;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (r_op_q == OP_SW);
        if (mem_ready) begin
          if (r_op_q == OP_SW) begin
            instr_done   = 1'b1;
            w_next_state = S_FETCH;
          end else begin
            w_next_state = S_WB;
          end
        end else if (w_wd_expire) begin
          w_next_state = S_ERR;
        end
      end
      S_WB: begin
        reg_write    = 1'b1;
        instr_done   = 1'b1;
        reg_dst      = is_rtype(r_op_q);
        mem_to_reg   = ~is_rtype(r_op_q);
        w_next_state = S_FETCH;
      end
      S_ERR:   w_next_state = S_ERR;
      default: w_next_state = S_FETCH;
    endcase

    if (reset) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 3'b000;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      instr_done = 1'b0;
    end
  end

  // State, latched opcode, watchdog counter and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_op_q     <= 4'd0;
      r_wait_cnt <= '0;
      r_illegal  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_DECODE) begin
        r_op_q <= instr_op;
      end
      if (w_next_state != r_state) begin
        r_wait_cnt <= '0;
      end else if (w_wait) begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end
      if ((r_state == S_DECODE) && (w_next_state == S_ERR)) begin
        r_illegal <= 1'b1;
      end
      if (w_wd_expire) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign illegal = r_illegal;
  assign timeout = r_timeout;
  assign state   = r_state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: a vector table of per-cycle inputs and
// hand-computed output words, plus hand-written error/watchdog sequences.
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] instr_op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, iord, ir_write, pc_write;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       reg_write, reg_dst, mem_to_reg, instr_done, illegal, timeout;
  logic [2:0] state;

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .instr_op(instr_op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .instr_done(instr_done), .illegal(illegal), .timeout(timeout), .state(state)
  );

  always #5 clk = ~clk;

  // Output word: {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
  //               alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, instr_done,
  //               illegal, timeout, state}
  localparam logic [21:0] MREQ   = 22'd1 << 21;
  localparam logic [21:0] MWE    = 22'd1 << 20;
  localparam logic [21:0] IORD   = 22'd1 << 19;
  localparam logic [21:0] IRW    = 22'd1 << 18;
  localparam logic [21:0] PCW    = 22'd1 << 17;
  localparam logic [21:0] PCS_AO = 22'd1 << 15;
  localparam logic [21:0] PCS_J  = 22'd2 << 15;
  localparam logic [21:0] ASA    = 22'd1 << 14;
  localparam logic [21:0] ASB_2  = 22'd1 << 12;
  localparam logic [21:0] ASB_I  = 22'd2 << 12;
  localparam logic [21:0] ASB_IS = 22'd3 << 12;
  localparam logic [21:0] A_SUB  = 22'd1 << 9;
  localparam logic [21:0] A_AND  = 22'd2 << 9;
  localparam logic [21:0] A_OR   = 22'd3 << 9;
  localparam logic [21:0] A_SLT  = 22'd4 << 9;
  localparam logic [21:0] RW     = 22'd1 << 8;
  localparam logic [21:0] RDST   = 22'd1 << 7;
  localparam logic [21:0] M2R    = 22'd1 << 6;
  localparam logic [21:0] DONE   = 22'd1 << 5;
  localparam logic [21:0] ILL    = 22'd1 << 4;
  localparam logic [21:0] TMO    = 22'd1 << 3;
  localparam logic [21:0] S_F = 22'd0, S_D = 22'd1, S_X = 22'd2, S_M = 22'd3,
                          S_W = 22'd4, S_E = 22'd7;

  localparam logic [21:0] F_OK   = MREQ | IRW | PCW | ASB_2 | S_F;
  localparam logic [21:0] F_WAIT = MREQ | S_F;
  localparam logic [21:0] DEC    = ASB_IS | S_D;
  localparam logic [21:0] WB_R   = RW | RDST | DONE | S_W;
  localparam logic [21:0] WB_LW  = RW | M2R | DONE | S_W;
  localparam logic [21:0] X_MEM  = ASA | ASB_I | S_X;
  localparam logic [21:0] M_WAIT = MREQ | IORD | S_M;

  typedef struct {
    logic        rst;
    logic [3:0]  op;
    logic        z;
    logic        rdy;
    logic [21:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic rst, input logic [3:0] op, input logic z,
                     input logic rdy, input logic [21:0] exp);
    vec_t v;
    v.rst = rst; v.op = op; v.z = z; v.rdy = rdy; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, compare mid-cycle, then advance past the edge.
  task automatic step(input string tag, input int idx, input logic rst,
                      input logic [3:0] op, input logic z, input logic rdy,
                      input logic [21:0] exp);
    logic [21:0] act;
    reset = rst; instr_op = op; zero = z; mem_ready = rdy;
    @(negedge clk);
    act = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
           alu_op, reg_write, reg_dst, mem_to_reg, instr_done, illegal, timeout, state};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: outputs got %06h expected %06h (state got %0d expected %0d)",
               tag, idx, act, exp, act[2:0], exp[2:0]);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; instr_op = 4'd0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;

    add(1, 4'd2, 0, 1, S_F);                     // reset: strobes masked, FETCH
    // ADD
    add(0, 4'd2, 0, 1, F_OK);
    add(0, 4'd2, 0, 1, DEC);
    add(0, 4'd2, 0, 1, ASA | S_X);
    add(0, 4'd2, 0, 1, WB_R);
    // LW with 3 MEM wait states
    add(0, 4'd8, 0, 1, F_OK);
    add(0, 4'd8, 0, 1, DEC);
    add(0, 4'd8, 0, 1, X_MEM);
    add(0, 4'd8, 0, 0, M_WAIT);
    add(0, 4'd8, 0, 0, M_WAIT);
    add(0, 4'd8, 0, 0, M_WAIT);
    add(0, 4'd8, 0, 1, M_WAIT);
    add(0, 4'd8, 0, 1, WB_LW);
    // BNE taken, then not taken
    add(0, 4'd14, 0, 1, F_OK);
    add(0, 4'd14, 0, 1, DEC);
    add(0, 4'd14, 0, 1, ASA | A_SUB | PCS_AO | PCW | DONE | S_X);
    add(0, 4'd14, 1, 1, F_OK);
    add(0, 4'd14, 1, 1, DEC);
    add(0, 4'd14, 1, 1, ASA | A_SUB | PCS_AO | DONE | S_X);
    // JMP
    add(0, 4'd15, 0, 1, F_OK);
    add(0, 4'd15, 0, 1, DEC | PCW | PCS_J | DONE);
    // SW, zero wait
    add(0, 4'd10, 0, 1, F_OK);
    add(0, 4'd10, 0, 1, DEC);
    add(0, 4'd10, 0, 1, X_MEM);
    add(0, 4'd10, 0, 1, M_WAIT | MWE | DONE);
    // SUB, SLT, AND, OR
    add(0, 4'd6, 0, 1, F_OK);  add(0, 4'd6, 0, 1, DEC);
    add(0, 4'd6, 0, 1, ASA | A_SUB | S_X);  add(0, 4'd6, 0, 1, WB_R);
    add(0, 4'd7, 0, 1, F_OK);  add(0, 4'd7, 0, 1, DEC);
    add(0, 4'd7, 0, 1, ASA | A_SLT | S_X);  add(0, 4'd7, 0, 1, WB_R);
    add(0, 4'd0, 0, 1, F_OK);  add(0, 4'd0, 0, 1, DEC);
    add(0, 4'd0, 0, 1, ASA | A_AND | S_X);  add(0, 4'd0, 0, 1, WB_R);
    add(0, 4'd1, 0, 1, F_OK);  add(0, 4'd1, 0, 1, DEC);
    add(0, 4'd1, 0, 1, ASA | A_OR | S_X);   add(0, 4'd1, 0, 1, WB_R);
    // LW with 3 FETCH waits then 3 MEM waits: one short of timeout, counter clears per phase
    add(0, 4'd8, 0, 0, F_WAIT); add(0, 4'd8, 0, 0, F_WAIT); add(0, 4'd8, 0, 0, F_WAIT);
    add(0, 4'd8, 0, 1, F_OK);
    add(0, 4'd8, 0, 1, DEC);
    add(0, 4'd8, 0, 1, X_MEM);
    add(0, 4'd8, 0, 0, M_WAIT); add(0, 4'd8, 0, 0, M_WAIT); add(0, 4'd8, 0, 0, M_WAIT);
    add(0, 4'd8, 0, 1, M_WAIT);
    add(0, 4'd8, 0, 1, WB_LW);
    // SW with reset asserted mid-access in MEM
    add(0, 4'd10, 0, 1, F_OK);
    add(0, 4'd10, 0, 1, DEC);
    add(0, 4'd10, 0, 1, X_MEM);
    add(0, 4'd10, 0, 0, M_WAIT | MWE);
    add(1, 4'd10, 0, 0, S_M);
    add(0, 4'd10, 0, 0, F_WAIT);

    for (int i = 0; i < vecs.size(); i++)
      step("vec", i, vecs[i].rst, vecs[i].op, vecs[i].z, vecs[i].rdy, vecs[i].exp);

    // Illegal opcode parks in ERR with no strobes until reset
    step("ill_rst", 0, 1, 4'd3, 0, 1, S_F);
    step("ill_fetch", 0, 0, 4'd3, 0, 1, F_OK);
    step("ill_dec", 0, 0, 4'd3, 0, 1, DEC);
    for (int i = 0; i < 20; i++)
      step("ill_hold", i, 0, 4'd15, 1'(i), 1'(i >> 1), ILL | S_E);
    step("ill_reset", 0, 1, 4'd15, 0, 1, ILL | S_E);
    step("ill_after", 0, 0, 4'd2, 0, 0, F_WAIT);

    // Watchdog: four FETCH wait cycles at MEM_TIMEOUT=4 expire into ERR
    step("wd_rst", 0, 1, 4'd2, 0, 0, S_F);
    for (int i = 0; i < 4; i++)
      step("wd_wait", i, 0, 4'd2, 0, 0, F_WAIT);
    step("wd_err", 0, 0, 4'd2, 0, 1, TMO | S_E);
    step("wd_hold", 0, 0, 4'd2, 0, 1, TMO | S_E);
    step("wd_reset", 0, 1, 4'd2, 0, 1, TMO | S_E);
    step("wd_after", 0, 0, 4'd2, 0, 1, F_OK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
